sdram_pattern_tester: RTL and testbench

Parametrised SDRAM built-in self-test engine. It sits between the host logic and the SDRAM frame-buffer controller's write-FIFO and read-FIFO ports. The engine replaces the fixed key-driven counter write and single-word read with the following sequence:
- a selectable data pattern is written over a programmable address span;
- the span is read back in full;
- every word is compared against a regenerated expected value;
- an error count and the first failing location are reported.

---
 rtl/sdram_pattern_tester.sv | 235 +++++++++++++++++++++++
 tb/tb_sdram_pattern_tester.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_pattern_tester.sv
// SDRAM built-in self-test: writes a pattern over a span, reads it back, counts mismatches.
// Optional SDRAM_TEST_ERR_INJECT_EN adds err_inject, which flips bit 0 of word 0 on write.
module sdram_pattern_tester #(
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       LEN_W     = 9,
    parameter int unsigned       RD_LAT    = 1,
    parameter int unsigned       FLUSH_CYC = 64,
    parameter logic [DATA_W-1:0] LFSR_TAPS = 16'hB400
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [LEN_W-1:0]  length,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_load,
    input  logic              rd_avail,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rd_load,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [LEN_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_data
`ifdef SDRAM_TEST_ERR_INJECT_EN
    ,
    input  logic              err_inject
`endif
);

    localparam int unsigned FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam int unsigned DC_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WRITE, S_FLUSH, S_READ, S_DRAIN, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DATA_W-1:0]   gen_q, gen_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [FC_W-1:0]     fcnt_q, fcnt_d;
    logic [DC_W-1:0]     dcnt_q, dcnt_d;
    logic [RD_LAT-1:0]   pv_q, pv_d;
    logic [DATA_W-1:0]   pe_q [RD_LAT];
    logic [DATA_W-1:0]   pe_d [RD_LAT];
    logic [LEN_W-1:0]    pi_q [RD_LAT];
    logic [LEN_W-1:0]    pi_d [RD_LAT];
    logic [15:0]         err_q, err_d;
    logic [LEN_W-1:0]    fidx_q, fidx_d;
    logic [DATA_W-1:0]   fdat_q, fdat_d;
    logic [DATA_W-1:0]   pat;
`ifdef SDRAM_TEST_ERR_INJECT_EN
    logic                inj_q, inj_d;
`endif

    function automatic logic [DATA_W-1:0] gen_init(input logic [1:0] m, input logic [DATA_W-1:0] s);
        if ((m == 2'd1 || m == 2'd2) && s == '0)
            return DATA_W'(1);
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] gen_next(input logic [1:0] m, input logic [DATA_W-1:0] g);
        case (m)
            2'd1:    return {g[DATA_W-2:0], g[DATA_W-1]};
            2'd2:    return (g >> 1) ^ (g[0] ? LFSR_TAPS : '0);
            default: return g + DATA_W'(1);
        endcase
    endfunction

    // Inverted-count runs the plain counter internally and inverts at the output.
    assign pat = (mode_q == 2'd3) ? ~gen_q : gen_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            seed_q  <= '0;
            len_q   <= '0;
            gen_q   <= '0;
            idx_q   <= '0;
            fcnt_q  <= '0;
            dcnt_q  <= '0;
            pv_q    <= '0;
            pe_q    <= '{default: '0};
            pi_q    <= '{default: '0};
            err_q   <= '0;
            fidx_q  <= '0;
            fdat_q  <= '0;
`ifdef SDRAM_TEST_ERR_INJECT_EN
            inj_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            seed_q  <= seed_d;
            len_q   <= len_d;
            gen_q   <= gen_d;
            idx_q   <= idx_d;
            fcnt_q  <= fcnt_d;
            dcnt_q  <= dcnt_d;
            pv_q    <= pv_d;
            pe_q    <= pe_d;
            pi_q    <= pi_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fdat_q  <= fdat_d;
`ifdef SDRAM_TEST_ERR_INJECT_EN
            inj_q   <= inj_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        seed_d  = seed_q;
        len_d   = len_q;
        gen_d   = gen_q;
        idx_d   = idx_q;
        fcnt_d  = fcnt_q;
        dcnt_d  = dcnt_q;
        err_d   = err_q;
        fidx_d  = fidx_q;
        fdat_d  = fdat_q;
`ifdef SDRAM_TEST_ERR_INJECT_EN
        inj_d   = inj_q;
`endif
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;

        // Compare stage: the tail of the pipeline lines up with rd_data.
        if (pv_q[RD_LAT-1] && rd_data != pe_q[RD_LAT-1]) begin
            if (err_q != '1)
                err_d = err_q + 16'd1;
            if (err_q == '0) begin
                fidx_d = pi_q[RD_LAT-1];
                fdat_d = rd_data;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mode_d  = mode;
                    seed_d  = seed;
                    len_d   = length;
                    err_d   = '0;
                    fidx_d  = '0;
                    fdat_d  = '0;
`ifdef SDRAM_TEST_ERR_INJECT_EN
                    inj_d   = err_inject;
`endif
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                gen_d   = gen_init(mode_q, seed_q);
                idx_d   = '0;
                state_d = (len_q == '0) ? S_DONE : S_WRITE;
            end
            S_WRITE: begin
                wr_data = pat;
`ifdef SDRAM_TEST_ERR_INJECT_EN
                if (inj_q && idx_q == '0)
                    wr_data = pat ^ DATA_W'(1);
`endif
                if (wr_ready) begin
                    wr_en = 1'b1;
                    gen_d = gen_next(mode_q, gen_q);
                    idx_d = idx_q + LEN_W'(1);
                    if (idx_q == len_q - LEN_W'(1)) begin
                        fcnt_d  = '0;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                fcnt_d = fcnt_q + FC_W'(1);
                if (fcnt_q == FC_W'(FLUSH_CYC - 1)) begin
                    gen_d   = gen_init(mode_q, seed_q);
                    idx_d   = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (rd_avail && idx_q < len_q) begin
                    rd_en = 1'b1;
                    gen_d = gen_next(mode_q, gen_q);
                    idx_d = idx_q + LEN_W'(1);
                    if (idx_q == len_q - LEN_W'(1)) begin
                        dcnt_d  = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                dcnt_d = dcnt_q + DC_W'(1);
                if (dcnt_q == DC_W'(RD_LAT - 1))
                    state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        pv_d    = pv_q;
        pe_d    = pe_q;
        pi_d    = pi_q;
        pv_d[0] = rd_en;
        pe_d[0] = pat;
        pi_d[0] = idx_q;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pe_d[i] = pe_q[i-1];
            pi_d[i] = pi_q[i-1];
        end
    end

    assign wr_load        = (state_q == S_LOAD);
    assign rd_load        = (state_q == S_LOAD) || (state_q == S_WRITE) || (state_q == S_FLUSH);
    assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done           = (state_q == S_DONE);
    assign pass           = done && (err_q == '0);
    assign err_count      = err_q;
    assign first_err_idx  = fidx_q;
    assign first_err_data = fdat_q;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Directed bench for sdram_pattern_tester with an ideal/corruptible SDRAM model
// and a write-data scoreboard fed from an independent pattern model.
module tb_sdram_pattern_tester;

    logic        clk = 1'b0;
    logic        reset, start, wr_ready, rd_avail;
    logic [1:0]  mode;
    logic [15:0] seed, wr_data, rd_data, err_count, first_err_data;
    logic [8:0]  length, first_err_idx;
    logic        wr_en, wr_load, rd_en, rd_load, busy, done, pass;
`ifdef SDRAM_TEST_ERR_INJECT_EN
    logic        err_inject = 1'b0;
`endif

    always #5 clk = ~clk;

    sdram_pattern_tester #(.DATA_W(16), .LEN_W(9), .RD_LAT(1), .FLUSH_CYC(64), .LFSR_TAPS(16'hB400)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .seed(seed), .length(length),
        .wr_ready(wr_ready), .wr_en(wr_en), .wr_data(wr_data), .wr_load(wr_load),
        .rd_avail(rd_avail), .rd_en(rd_en), .rd_data(rd_data), .rd_load(rd_load),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_data(first_err_data)
`ifdef SDRAM_TEST_ERR_INJECT_EN
        , .err_inject(err_inject)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          cor_a = -1, cor_b = -1;
    logic [15:0] cor_ma = '0, cor_mb = '0;
    logic [15:0] sb [$];
    logic [15:0] mem [0:511];
    logic [8:0]  waddr = '0, raddr = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [1:0] m, input logic [15:0] s, input int i);
        logic [15:0] v;
        int          r;
        v = (s == 16'h0) ? 16'h0001 : s;
        case (m)
            2'd0: return s + 16'(i);
            2'd3: return ~(s + 16'(i));
            2'd1: begin
                r = i % 16;
                return (v << r) | (v >> ((16 - r) % 16));
            end
            default: begin
                for (int k = 0; k < i; k++)
                    v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
                return v;
            end
        endcase
    endfunction

    // SDRAM model: sequential write/read pointers reloaded by the load strobes.
    always @(posedge clk) begin
        if (wr_load) waddr <= '0;
        else if (wr_en) begin
            mem[waddr] <= wr_data;
            waddr      <= waddr + 9'd1;
        end
        if (rd_load) raddr <= '0;
        else if (rd_en) begin
            rd_data <= mem[raddr] ^ ((int'(raddr) == cor_a) ? cor_ma : 16'h0)
                                  ^ ((int'(raddr) == cor_b) ? cor_mb : 16'h0);
            raddr   <= raddr + 9'd1;
        end
    end

    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            check("wr_ready_gate", wr_ready, 1);
            check("sb_empty_on_wr", 32'(sb.size() == 0), 0);
            if (sb.size() > 0) check("wr_data", wr_data, sb.pop_front());
        end
        if (rd_en) begin
            rd_cnt++;
            check("rd_avail_gate", rd_avail, 1);
        end
    end

    task automatic run(input logic [1:0] m, input logic [15:0] s, input logic [8:0] l,
                       input bit inj, input bit stall, input bit midstart, output int cyc);
        logic [15:0] w;
        logic [3:0]  rdy_pat = 4'b1001;
        int          hold = 0;
        for (int i = 0; i < int'(l); i++) begin
            w = model(m, s, i);
            if (inj && i == 0) w = w ^ 16'h0001;
            sb.push_back(w);
        end
        wr_cnt = 0;
        rd_cnt = 0;
        mode = m; seed = s; length = l; start = 1'b1;
`ifdef SDRAM_TEST_ERR_INJECT_EN
        err_inject = inj;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        check("done_drop", done, 0);
        check("busy_set", busy, 1);
        while (!done && cyc < 3000) begin
            if (stall) begin
                wr_ready = rdy_pat[cyc % 4];
                rd_avail = !(rd_cnt >= 20 && hold < 10);
                if (!rd_avail) hold++;
            end
            start  = midstart && cyc == 10;
            length = midstart ? l + 9'd5 : l;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; wr_ready = 1'b1; rd_avail = 1'b1;
        check("done_reached", done, 1);
        check("wr_count", wr_cnt, l);
        check("rd_count", rd_cnt, l);
        check("sb_drained", sb.size(), 0);
        if (stall) check("rd_stall_len", hold, 10);
    endtask

    task automatic check_results(input logic [15:0] ec, input logic [8:0] fi, input logic [15:0] fd);
        check("err_count", err_count, ec);
        check("pass", pass, 32'(ec == 16'h0));
        check("first_err_idx", first_err_idx, fi);
        check("first_err_data", first_err_data, fd);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_wr_load"}, wr_load, 0);
        check({tag, "_rd_load"}, rd_load, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err"}, err_count, 0);
        check({tag, "_fidx"}, first_err_idx, 0);
        check({tag, "_fdat"}, first_err_data, 0);
    endtask

    initial begin
        int cyc;
        int snap_rd, snap_wr;
        reset = 1'b1; start = 1'b0; mode = '0; seed = '0; length = '0;
        wr_ready = 1'b1; rd_avail = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;

        // Count mode, full-rate: exact start-to-done latency.
        run(2'd0, 16'h0000, 9'd256, 0, 0, 0, cyc);
        check("count_latency", cyc, 2 + 512 + 64 + 1);
        check_results(16'h0, 9'h0, 16'h0);

        run(2'd2, 16'h0000, 9'd32, 0, 0, 0, cyc);
        check_results(16'h0, 9'h0, 16'h0);
        run(2'd1, 16'h0003, 9'd20, 0, 0, 0, cyc);
        check_results(16'h0, 9'h0, 16'h0);
        run(2'd3, 16'h00F0, 9'd40, 0, 0, 0, cyc);
        check_results(16'h0, 9'h0, 16'h0);

        // Read-back corruption at words 5 and 9.
        cor_a = 5; cor_ma = 16'h0010; cor_b = 9; cor_mb = 16'h0100;
        run(2'd0, 16'h1000, 9'd16, 0, 0, 0, cyc);
        check_results(16'h2, 9'd5, 16'h1015);
        cor_a = -1; cor_b = -1;

        run(2'd2, 16'hACE1, 9'd64, 0, 1, 0, cyc);
        check_results(16'h0, 9'h0, 16'h0);

        // start pulse while busy must not alter the run in progress.
        run(2'd0, 16'h0055, 9'd8, 0, 0, 1, cyc);
        check("busy_start_latency", cyc, 2 + 16 + 64 + 1);
        check_results(16'h0, 9'h0, 16'h0);

        // Abort in the third READ cycle.
        for (int i = 0; i < 16; i++) sb.push_back(model(2'd0, 16'h0020, i));
        mode = 2'd0; seed = 16'h0020; length = 9'd16; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 200 && !rd_en; k++) begin
            @(posedge clk); #1;
        end
        check("abort_reached_read", rd_en, 1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check_zero("abort");
        reset = 1'b0;
        sb.delete();
        snap_rd = rd_cnt; snap_wr = wr_cnt;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("abort_no_rd", rd_cnt, snap_rd);
        check("abort_no_wr", wr_cnt, snap_wr);

        run(2'd0, 16'h1234, 9'd0, 0, 0, 0, cyc);
        check("len0_latency", cyc, 2);
        check_results(16'h0, 9'h0, 16'h0);

`ifdef SDRAM_TEST_ERR_INJECT_EN
        run(2'd1, 16'h0001, 9'd16, 1, 0, 0, cyc);
        check_results(16'h1, 9'd0, 16'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
